// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Initiator for a combinational 2-bit-opcode ALU (code/a/b -> c).
//   Commands arrive on a valid/ready port. Each command drives alu_* for
//   SETTLE cycles, then alu_c is sampled. The sampled result and its opcode
//   are queued in a DEPTH-entry FIFO for a downstream consumer.
//
// Parameters
//   WIDTH   operand/result width
//   SETTLE  cycles alu_* are held before alu_c is sampled (1..15)
//   DEPTH   result FIFO entries (power of two, >= 2)
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o     command handshake
//   cmd_code_i                    00 AND, 01 OR, 10 SUB (a-b), 11 ADD
//   cmd_a_i, cmd_b_i              operands
//   alu_code_o, alu_a_o, alu_b_o  registered drive to the external ALU
//   alu_c_i                       ALU result (combinational from alu_*)
//   res_valid_o / res_ready_i     result handshake (FIFO not empty / pop)
//   res_data_o, res_code_o        FIFO head (0 while empty)
//   busy_o                        an operation is in flight
//
// Optional feature: macro ALU_CHAIN_EN adds cmd_chain_i. When it is set at
// accept, alu_a is loaded from the most recently captured result instead
// of cmd_a_i.
module alu_op_sequencer #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1,
  parameter int DEPTH  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_code_i,
  input  logic [WIDTH-1:0] cmd_a_i,
  input  logic [WIDTH-1:0] cmd_b_i,
`ifdef ALU_CHAIN_EN
  input  logic             cmd_chain_i,
`endif
  output logic [1:0]       alu_code_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic [WIDTH-1:0] alu_c_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_data_o,
  output logic [1:0]       res_code_o,
  output logic             busy_o
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, DRIVE} state_e;

  typedef struct packed {
    logic [1:0]       code;
    logic [WIDTH-1:0] data;
  } res_t;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       alu_code_q, alu_code_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  res_t             mem_q [DEPTH];
  logic             push, pop;

`ifdef ALU_CHAIN_EN
  // Last captured alu_c; independent of the FIFO so pops do not disturb it.
  logic [WIDTH-1:0] last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)     last_q <= '0;
    else if (push) last_q <= alu_c_i;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_code_d  = alu_code_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    cmd_ready_o = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Only accept when the eventual push is guaranteed a free slot.
        cmd_ready_o = (count_q < FULL);
        if (cmd_valid_i && cmd_ready_o) begin
          alu_code_d = cmd_code_i;
          alu_a_d    = cmd_a_i;
`ifdef ALU_CHAIN_EN
          if (cmd_chain_i) alu_a_d = last_q;
`endif
          alu_b_d    = cmd_b_i;
          cnt_d      = 4'(SETTLE);
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pop on an empty FIFO is dropped so the read pointer stays put.
  assign pop = res_ready_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? AW'(1) : AW'(0));
    rd_ptr_d = rd_ptr_q + (pop  ? AW'(1) : AW'(0));
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      alu_code_q <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_code_q <= alu_code_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: contents are masked by count_q.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem_q[wr_ptr_q] <= {alu_code_q, alu_c_i};
  end

  assign alu_code_o  = alu_code_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign res_valid_o = (count_q != '0);
  assign res_data_o  = res_valid_o ? mem_q[rd_ptr_q].data : '0;
  assign res_code_o  = res_valid_o ? mem_q[rd_ptr_q].code : '0;
  assign busy_o      = (state_q == DRIVE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  localparam int WIDTH  = 4;
  localparam int SETTLE = 1;
  localparam int DEPTH  = 4;
  localparam int MOD    = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0, cmd_ready;
  logic [1:0]       cmd_code = '0;
  logic [WIDTH-1:0] cmd_a = '0, cmd_b = '0;
  logic             cmd_chain = 1'b0;
  logic [1:0]       alu_code;
  logic [WIDTH-1:0] alu_a, alu_b, alu_c;
  logic             res_valid, res_ready = 1'b0;
  logic [WIDTH-1:0] res_data;
  logic [1:0]       res_code;
  logic             busy;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(WIDTH), .SETTLE(SETTLE), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_code_i(cmd_code), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
`ifdef ALU_CHAIN_EN
    .cmd_chain_i(cmd_chain),
`endif
    .alu_code_o(alu_code), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_c_i(alu_c),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_code_o(res_code), .busy_o(busy)
  );

  // External combinational ALU.
  always_comb begin
    alu_c = '0;
    case (alu_code)
      2'b00: alu_c = alu_a & alu_b;
      2'b01: alu_c = alu_a | alu_b;
      2'b10: alu_c = alu_a - alu_b;
      default: alu_c = alu_a + alu_b;
    endcase
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic over a queue of results.
  typedef struct { int code; int data; } m_res_t;
  m_res_t mq[$];
  bit     m_busy = 0;
  int     m_rem = 0, m_last = 0, m_a = 0, m_b = 0, m_code = 0;
  m_res_t m_pend;

  function automatic int ref_op(input int code, input int a, input int b);
    case (code)
      0: return a & b;
      1: return a | b;
      2: return ((a - b) % MOD + MOD) % MOD;
      default: return (a + b) % MOD;
    endcase
  endfunction

  // One clock: check outputs against the model, advance DUT and model.
  task automatic cycle();
    int  sz = mq.size();
    bit  acc, pp;
    int  ca, cb, cc;
    chk("cmd_ready", cmd_ready, 32'(!m_busy && sz < DEPTH));
    chk("res_valid", res_valid, 32'(sz > 0));
    chk("busy", busy, 32'(m_busy));
    chk("res_data", res_data, sz > 0 ? mq[0].data : 0);
    chk("res_code", res_code, sz > 0 ? mq[0].code : 0);
    chk("alu_code", alu_code, m_code);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    acc = cmd_valid && !m_busy && sz < DEPTH;
    pp  = res_ready && sz > 0;
    cc = int'(cmd_code); ca = int'(cmd_a); cb = int'(cmd_b);
`ifdef ALU_CHAIN_EN
    if (cmd_chain) ca = m_last;
`endif
    @(posedge clk); #1;
    if (rst) begin
      mq.delete(); m_busy = 0; m_last = 0; m_a = 0; m_b = 0; m_code = 0; m_rem = 0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (m_busy) begin
        if (m_rem == 1) begin
          mq.push_back(m_pend); m_last = m_pend.data; m_busy = 0;
        end else m_rem--;
      end
      if (acc) begin
        m_busy = 1; m_rem = SETTLE; m_code = cc; m_a = ca; m_b = cb;
        m_pend.code = cc; m_pend.data = ref_op(cc, ca, cb);
      end
    end
  endtask

  task automatic issue(input int c, input int a, input int b, input bit ch);
    int n = 0;
    while (!cmd_ready && n < 100) begin cycle(); n++; end
    if (!cmd_ready) chk("issue_timeout", 0, 1);
    cmd_valid = 1'b1; cmd_code = 2'(c); cmd_a = WIDTH'(a); cmd_b = WIDTH'(b); cmd_chain = ch;
    cycle();
    cmd_valid = 1'b0; cmd_chain = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    res_ready = 1'b1;
    while (res_valid && n < 40) begin cycle(); n++; end
    res_ready = 1'b0;
    chk("drain_empty", res_valid, 0);
  endtask

  typedef struct { int code; int a; int b; int exp; } vec_t;
  vec_t vt[4];

  initial begin
    vt[0] = '{0, 13, 12, 12};
    vt[1] = '{1, 13, 12, 13};
    vt[2] = '{2, 13, 12, 1};
    vt[3] = '{3, 13, 12, 9};

    // Two cycles of reset, then the first cycle() checks reset outputs.
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    cycle();

    // Directed table: each result appears exactly SETTLE cycles after accept.
    foreach (vt[i]) begin
      issue(vt[i].code, vt[i].a, vt[i].b, 1'b0);
      for (int k = 0; k < SETTLE; k++) cycle();
      chk("tbl_latency", res_valid, 1);
      chk("tbl_data", res_data, vt[i].exp);
      chk("tbl_code", res_code, vt[i].code);
      res_ready = 1'b1; cycle(); res_ready = 1'b0;
    end

    // Fill FIFO with no pops, hold a 5th command, pop one, 5th completes.
    for (int i = 0; i < DEPTH; i++) issue(i % 4, i + 3, 2, 1'b0);
    cmd_valid = 1'b1; cmd_code = 2'b11; cmd_a = 4'd1; cmd_b = 4'd1;
    for (int k = 0; k < SETTLE + 2; k++) cycle();
    chk("full_ready", cmd_ready, 0);
    res_ready = 1'b1; cycle(); res_ready = 1'b0;
    chk("ready_after_pop", cmd_ready, 1);
    cycle();
    cmd_valid = 1'b0;
    for (int k = 0; k < SETTLE; k++) cycle();
    chk("full_again_count", res_valid, 1);
    drain();

    // Reset during DRIVE with two results queued.
    issue(3, 1, 2, 1'b0);
    issue(3, 2, 2, 1'b0);
    issue(3, 5, 5, 1'b0);
    chk("rst_mid_busy", busy, 1);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("rst_mid_res_valid", res_valid, 0);
    chk("rst_mid_busy_clr", busy, 0);
    for (int k = 0; k < SETTLE + 3; k++) cycle();
    chk("rst_no_ghost", res_valid, 0);

    // count==1: pop lands on the same edge as a push.
    issue(0, 13, 12, 1'b0);
    for (int k = 0; k < SETTLE; k++) cycle();
    issue(3, 3, 4, 1'b0);
    for (int k = 0; k < SETTLE - 1; k++) cycle();
    res_ready = 1'b1; cycle(); res_ready = 1'b0;
    chk("pushpop_valid", res_valid, 1);
    chk("pushpop_head", res_data, 7);
    drain();

`ifdef ALU_CHAIN_EN
    issue(3, 3, 1, 1'b0);
    for (int k = 0; k < SETTLE; k++) cycle();
    chk("chain_first", res_data, 4);
    drain();
    issue(3, 15, 2, 1'b1);
    for (int k = 0; k < SETTLE; k++) cycle();
    chk("chain_second", res_data, 6);
    drain();
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_code  = 2'($urandom_range(0, 3));
      cmd_a     = WIDTH'($urandom);
      cmd_b     = WIDTH'($urandom);
      cmd_chain = ($urandom_range(0, 3) == 0);
      res_ready = ($urandom_range(0, 2) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0; cmd_valid = 1'b0; cmd_chain = 1'b0;
    for (int k = 0; k < SETTLE + 1; k++) cycle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
